// File: rtl/shift_clock_ctrl.sv
// shift_clock_ctrl: run-time controller for the backscatter shift clock.
// Generates clock_out from a programmable half-period. Starts and stops are
// aligned so that a high phase always runs its full length. Half-period
// updates arrive over a valid/ready handshake and take effect on a toggle
// boundary, or at once while idle.
//
// Ports:
//   clock_in  - single clock, rising edge
//   reset     - synchronous, active-high
//   run       - level request: 1 = run, 0 = stop
//   cfg_valid - new half-period offered
//   cfg_half  - requested half-period (0 is rejected)
//   cfg_ready - a config can be accepted
//   cfg_err   - one-cycle pulse when a half-period of 0 is rejected
//   applied   - one-cycle pulse when a new half-period takes effect
//   clock_out - generated shift clock
//   edge_stb  - high in each cycle where clock_out holds a newly toggled value
//   busy      - controller is not idle
module shift_clock_ctrl #(
  parameter int unsigned CNT_W        = 12,
  parameter int unsigned DEFAULT_HALF = 5
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             run,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             applied,
  output logic             clock_out,
  output logic             edge_stb,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] active_half;
  logic [CNT_W-1:0] pending_half;
  logic             pending;

  logic accept;
  logic accept_ok;
  logic tog;

  assign cfg_ready = ~pending;
  assign busy      = (state != IDLE);
  assign accept    = cfg_valid & cfg_ready;
  assign accept_ok = accept & (cfg_half != '0);
  // active_half is never 0, so the subtraction cannot wrap.
  assign tog       = (counter == active_half - CNT_W'(1));

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state        <= IDLE;
      counter      <= '0;
      clock_out    <= 1'b0;
      edge_stb     <= 1'b0;
      applied      <= 1'b0;
      cfg_err      <= 1'b0;
      pending      <= 1'b0;
      pending_half <= '0;
      active_half  <= CNT_W'(DEFAULT_HALF);
    end else begin
      edge_stb <= 1'b0;
      applied  <= 1'b0;
      cfg_err  <= accept & (cfg_half == '0);

      unique case (state)
        IDLE: begin
          counter   <= '0;
          clock_out <= 1'b0;
          // A config accepted on the very edge that entered IDLE is left
          // pending; it is applied here on the first idle cycle.
          if (pending) begin
            active_half <= pending_half;
            pending     <= 1'b0;
            applied     <= 1'b1;
          end else if (accept_ok) begin
            active_half <= cfg_half;
            applied     <= 1'b1;
          end
          if (run) state <= RUN;
        end

        RUN, STOPPING: begin
          if (state == RUN && !run && !clock_out) begin
            // Stop during a low phase: truncate it, no further toggle.
            state   <= IDLE;
            counter <= '0;
            if (pending) begin
              active_half <= pending_half;
              pending     <= 1'b0;
              applied     <= 1'b1;
            end else if (accept_ok) begin
              pending_half <= cfg_half;
              pending      <= 1'b1;
            end
          end else begin
            if (state == RUN && !run) state <= STOPPING;
            if (tog) begin
              counter   <= '0;
              clock_out <= ~clock_out;
              edge_stb  <= 1'b1;
              // Falling toggle with a stop requested ends the run. This
              // covers both STOPPING and a stop arriving on the toggle edge.
              if (clock_out && (state == STOPPING || !run)) state <= IDLE;
              if (pending) begin
                active_half <= pending_half;
                pending     <= 1'b0;
                applied     <= 1'b1;
              end
            end else begin
              counter <= counter + CNT_W'(1);
            end
            // Acceptance requires !pending, so this never collides with the
            // apply above; a toggle on the accept edge uses the old value.
            if (accept_ok) begin
              pending_half <= cfg_half;
              pending      <= 1'b1;
            end
          end
        end

        default: begin
          state     <= IDLE;
          counter   <= '0;
          clock_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_clock_ctrl.sv
// Testbench for shift_clock_ctrl. Expected toggle, applied and cfg_err
// events (with the cycle they must appear) are queued as stimulus is driven;
// a negedge monitor pops and compares them when the DUT pulses.
module tb_shift_clock_ctrl;

  localparam int unsigned CNT_W = 12;

  logic             clk;
  logic             reset;
  logic             run;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_half;
  logic             cfg_ready;
  logic             cfg_err;
  logic             applied;
  logic             clock_out;
  logic             edge_stb;
  logic             busy;

  shift_clock_ctrl #(.CNT_W(CNT_W), .DEFAULT_HALF(5)) dut (
    .clock_in  (clk),
    .reset     (reset),
    .run       (run),
    .cfg_valid (cfg_valid),
    .cfg_half  (cfg_half),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .applied   (applied),
    .clock_out (clock_out),
    .edge_stb  (edge_stb),
    .busy      (busy)
  );

  typedef struct {
    int unsigned cyc;
    logic        val;
  } tog_t;

  tog_t        tog_q[$];
  int unsigned app_q[$];
  int unsigned err_q[$];

  int unsigned cyc = 0;
  int unsigned passed = 0;
  int unsigned total = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Monitor: every pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (edge_stb === 1'b1) begin
      chk("edge_expected", 32'(tog_q.size() != 0), 32'd1);
      if (tog_q.size() != 0) begin
        tog_t t;
        t = tog_q.pop_front();
        chk("edge_cycle", cyc, t.cyc);
        chk("edge_value", 32'(clock_out), 32'(t.val));
      end
    end
    if (applied === 1'b1) begin
      chk("applied_expected", 32'(app_q.size() != 0), 32'd1);
      if (app_q.size() != 0) chk("applied_cycle", cyc, app_q.pop_front());
    end
    if (cfg_err === 1'b1) begin
      chk("cfg_err_expected", 32'(err_q.size() != 0), 32'd1);
      if (err_q.size() != 0) chk("cfg_err_cycle", cyc, err_q.pop_front());
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_to(input int unsigned n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic push_tog(input int unsigned c, input logic v);
    tog_t t;
    t.cyc = c;
    t.val = v;
    tog_q.push_back(t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned e0, r, e1, e2, e3, e4;
    reset = 1'b1; run = 1'b0; cfg_valid = 1'b0; cfg_half = '0;
    repeat (3) step();

    // Reset state
    chk("rst_clock_out", 32'(clock_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_edge_stb", 32'(edge_stb), 32'd0);
    chk("rst_applied", 32'(applied), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    reset = 1'b0;
    step();

    // 1. Start at default half-period 5
    run = 1'b1;
    e0 = cyc + 1;
    for (int unsigned k = 1; k <= 5; k++) push_tog(e0 + 5 * k, logic'(k % 2));
    wait_to(e0);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_clock_low", 32'(clock_out), 32'd0);
    wait_to(e0 + 4);
    chk("start_still_low", 32'(clock_out), 32'd0);

    // 3. Illegal config during a low phase
    wait_to(e0 + 11);
    cfg_valid = 1'b1; cfg_half = '0;
    err_q.push_back(e0 + 12);
    step();
    cfg_valid = 1'b0;
    chk("illegal_cfg_ready", 32'(cfg_ready), 32'd1);

    // 2. Config half=2 two cycles into a high phase
    r = e0 + 25;
    wait_to(r + 1);
    chk("high_phase_level", 32'(clock_out), 32'd1);
    cfg_valid = 1'b1; cfg_half = 12'd2;
    app_q.push_back(r + 5);
    push_tog(r + 5, 1'b0);
    push_tog(r + 7, 1'b1);
    push_tog(r + 9, 1'b0);
    push_tog(r + 11, 1'b1);
    push_tog(r + 13, 1'b0);
    step();
    cfg_valid = 1'b0;
    chk("pend_ready_low", 32'(cfg_ready), 32'd0);
    wait_to(r + 4);
    chk("pend_ready_low_late", 32'(cfg_ready), 32'd0);
    chk("pend_high_held", 32'(clock_out), 32'd1);
    wait_to(r + 5);
    chk("applied_ready_high", 32'(cfg_ready), 32'd1);

    // 4b. Stop during a low phase
    wait_to(r + 13);
    run = 1'b0;
    step();
    chk("lowstop_busy", 32'(busy), 32'd0);
    chk("lowstop_clock", 32'(clock_out), 32'd0);

    // 4a. Stop one cycle into a high phase at half=5
    wait_to(r + 15);
    cfg_valid = 1'b1; cfg_half = 12'd5;
    app_q.push_back(r + 16);
    step();
    cfg_valid = 1'b0;
    chk("idle_cfg_ready", 32'(cfg_ready), 32'd1);
    run = 1'b1;
    e1 = cyc + 1;
    push_tog(e1 + 5, 1'b1);
    push_tog(e1 + 10, 1'b0);
    wait_to(e1 + 5);
    run = 1'b0;
    wait_to(e1 + 9);
    chk("highstop_busy", 32'(busy), 32'd1);
    chk("highstop_clock", 32'(clock_out), 32'd1);
    wait_to(e1 + 10);
    chk("highstop_done_busy", 32'(busy), 32'd0);
    chk("highstop_done_clock", 32'(clock_out), 32'd0);

    // 5. Minimum half-period 1 (divide-by-2)
    wait_to(e1 + 11);
    cfg_valid = 1'b1; cfg_half = 12'd1;
    app_q.push_back(e1 + 12);
    step();
    cfg_valid = 1'b0;
    run = 1'b1;
    e2 = cyc + 1;
    for (int unsigned k = 1; k <= 8; k++) push_tog(e2 + k, logic'(k % 2));
    wait_to(e2 + 8);
    run = 1'b0;
    step();
    chk("div2_stop_busy", 32'(busy), 32'd0);
    chk("div2_stop_clock", 32'(clock_out), 32'd0);

    // 6. Reset mid-run with a config pending
    wait_to(e2 + 10);
    cfg_valid = 1'b1; cfg_half = 12'd5;
    app_q.push_back(e2 + 11);
    step();
    cfg_valid = 1'b0;
    run = 1'b1;
    e3 = cyc + 1;
    push_tog(e3 + 5, 1'b1);
    wait_to(e3 + 6);
    cfg_valid = 1'b1; cfg_half = 12'd7;
    step();
    cfg_valid = 1'b0;
    chk("rst_pend_ready", 32'(cfg_ready), 32'd0);
    reset = 1'b1; run = 1'b0;
    step();
    chk("midrst_clock", 32'(clock_out), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(cfg_ready), 32'd1);
    reset = 1'b0;
    step();
    run = 1'b1;
    e4 = cyc + 1;
    for (int unsigned k = 1; k <= 4; k++) push_tog(e4 + 5 * k, logic'(k % 2));
    wait_to(e4 + 20);
    run = 1'b0;
    wait_to(e4 + 23);
    chk("final_busy", 32'(busy), 32'd0);

    // Every expected event must have been seen
    chk("tog_q_drained", tog_q.size(), 32'd0);
    chk("app_q_drained", app_q.size(), 32'd0);
    chk("err_q_drained", err_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
